// File: rtl/regdesloc_pkg.sv
// Shared opcodes, FSM state encoding and default widths for registrador_deslocamento.
// REGDESLOC_ROTACAO_EN enables the rotate opcodes (ROR/ROL).
package regdesloc_pkg;

  localparam int LARGURA_PADRAO   = 16;
  localparam int LARGURA_N_PADRAO = 4;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    DESLOCANDO = 2'b01,
    FIM        = 2'b10
  } estado_t;

  // True for opcodes that move bits; disabled rotates fall back to NOP.
  function automatic logic op_desloca(input logic [2:0] op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: return 1'b1;
`ifdef REGDESLOC_ROTACAO_EN
      OP_ROR, OP_ROL:         return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/desloca_um_bit.sv
// One-bit shift/rotate step; any non-moving opcode passes the word through.
// Rotate paths exist only when REGDESLOC_ROTACAO_EN is defined.
module desloca_um_bit
  import regdesloc_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic [2:0]         op_i,
  input  logic [LARGURA-1:0] palavra_i,
  output logic [LARGURA-1:0] palavra_o
);

  always_comb begin
    palavra_o = palavra_i;
    case (op_i)
      OP_SLL: palavra_o = {palavra_i[LARGURA-2:0], 1'b0};
      OP_SRL: palavra_o = {1'b0, palavra_i[LARGURA-1:1]};
      OP_SRA: palavra_o = {palavra_i[LARGURA-1], palavra_i[LARGURA-1:1]};
`ifdef REGDESLOC_ROTACAO_EN
      OP_ROR: palavra_o = {palavra_i[0], palavra_i[LARGURA-1:1]};
      OP_ROL: palavra_o = {palavra_i[LARGURA-2:0], palavra_i[LARGURA-1]};
`endif
      default: palavra_o = palavra_i;
    endcase
  end

endmodule

// File: rtl/registrador_deslocamento.sv
// Multicycle shift register with start/busy/done handshake, one bit per clock.
// REGDESLOC_ROTACAO_EN enables ROR/ROL; otherwise they complete as NOP.
//
// state      | meaning
// OCIOSO     | idle, waiting for inicio
// DESLOCANDO | applying one step per edge until count reaches 1
// FIM        | pronto high for one cycle, then back to OCIOSO
module registrador_deslocamento
  import regdesloc_pkg::*;
#(
  parameter int LARGURA   = LARGURA_PADRAO,
  parameter int LARGURA_N = LARGURA_N_PADRAO
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inicio,
  input  logic [2:0]           controle,
  input  logic [LARGURA-1:0]   entrada,
  input  logic [LARGURA_N-1:0] n,
  output logic [LARGURA-1:0]   saida,
  output logic                 ocupado,
  output logic                 pronto
);

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   saida_q, saida_d;
  logic [LARGURA_N-1:0] cont_q, cont_d;
  logic [2:0]           op_q, op_d;
  logic [LARGURA-1:0]   passo;

  desloca_um_bit #(.LARGURA(LARGURA)) u_passo (
    .op_i      (op_q),
    .palavra_i (saida_q),
    .palavra_o (passo)
  );

  always_comb begin
    estado_d = estado_q;
    saida_d  = saida_q;
    cont_d   = cont_q;
    op_d     = op_q;
    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          estado_d = DESLOCANDO;
          // Non-moving requests take one pass-through step so pronto lands after E1.
          if (op_desloca(controle) && (n != '0)) begin
            op_d   = controle;
            cont_d = n;
          end else begin
            op_d   = OP_NOP;
            cont_d = LARGURA_N'(1);
            if (controle == OP_LOAD) saida_d = entrada;
          end
        end
      end
      DESLOCANDO: begin
        saida_d = passo;
        cont_d  = cont_q - LARGURA_N'(1);
        if (cont_q == LARGURA_N'(1)) estado_d = FIM;
      end
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      saida_q  <= '0;
      cont_q   <= '0;
      op_q     <= OP_NOP;
    end else begin
      estado_q <= estado_d;
      saida_q  <= saida_d;
      cont_q   <= cont_d;
      op_q     <= op_d;
    end
  end

  assign saida   = saida_q;
  assign ocupado = (estado_q != OCIOSO);
  assign pronto  = (estado_q == FIM);

endmodule

// File: tb/tb_registrador_deslocamento.sv
// Self-checking bench for registrador_deslocamento: directed literal cases plus
// randomized transactions checked every cycle against a closed-form model.
module tb_registrador_deslocamento;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inicio = 1'b0;
  logic [2:0]  controle = 3'b000;
  logic [15:0] entrada = 16'h0;
  logic [3:0]  n = 4'h0;
  logic [15:0] saida;
  logic        ocupado, pronto;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

`ifdef REGDESLOC_ROTACAO_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  registrador_deslocamento dut (
    .clock    (clock),
    .reset    (reset),
    .inicio   (inicio),
    .controle (controle),
    .entrada  (entrada),
    .n        (n),
    .saida    (saida),
    .ocupado  (ocupado),
    .pronto   (pronto)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Closed-form result of applying op j times to w.
  function automatic logic [15:0] aplica(input logic [2:0] op, input logic [15:0] w, input int j);
    case (op)
      3'b010: return w << j;
      3'b011: return w >> j;
      3'b100: return 16'($signed(w) >>> j);
      3'b101: return (j == 0) ? w : ((w >> j) | (w << (16 - j)));
      3'b110: return (j == 0) ? w : ((w << j) | (w >> (16 - j)));
      default: return w;
    endcase
  endfunction

  function automatic bit move(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b011) || (op == 3'b100) ||
           (ROT && ((op == 3'b101) || (op == 3'b110)));
  endfunction

  // Model: one transaction = start edge E0, then L more busy cycles, pronto at t==L.
  logic [15:0] m_word = 16'h0, m_base = 16'h0;
  logic [2:0]  m_op = 3'b000;
  int m_steps = 0, m_L = 0, m_t = 0;
  bit m_busy = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_word = 16'h0;
      m_busy = 1'b0;
      m_t    = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t > m_L) m_busy = 1'b0;
      else m_word = aplica(m_op, m_base, (m_t < m_steps) ? m_t : m_steps);
    end else if (inicio) begin
      if (controle == 3'b001) m_word = entrada;
      m_base  = m_word;
      m_op    = controle;
      m_steps = (move(controle) && n != 4'd0) ? int'(n) : 0;
      m_L     = (m_steps > 0) ? m_steps : 1;
      m_t     = 0;
      m_busy  = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_saida", saida, m_word);
      chk("cyc_ocupado", ocupado, m_busy);
      chk("cyc_pronto", pronto, m_busy && (m_t == m_L));
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [3:0] nn, input logic [15:0] d,
                       input int inj_t, output logic [15:0] res, output int nbusy,
                       output int npronto, output int tpronto);
    bit fim;
    @(negedge clock);
    inicio = 1'b1; controle = op; n = nn; entrada = d;
    @(posedge clock);
    @(negedge clock);
    inicio = 1'b0; controle = 3'($urandom); n = 4'($urandom); entrada = 16'($urandom);
    nbusy = 0; npronto = 0; tpronto = -1; fim = 1'b0;
    for (int t = 0; t < 40 && !fim; t++) begin
      if (t > 0) @(negedge clock);
      if (!ocupado) fim = 1'b1;
      else begin
        nbusy++;
        if (pronto) begin npronto++; tpronto = t; end
        if (t == inj_t) begin inicio = 1'b1; controle = 3'b010; n = 4'd8; end
        else inicio = 1'b0;
      end
    end
    inicio = 1'b0;
    chk("timeout", ocupado, 1'b0);
    res = saida;
  endtask

  task automatic caso(input string nm, input logic [2:0] op, input logic [3:0] nn,
                      input logic [15:0] d, input logic [15:0] exp, input int exp_t, input int inj_t);
    logic [15:0] r; int nb, np, tp;
    do_op(op, nn, d, inj_t, r, nb, np, tp);
    chk({nm, "_saida"}, r, exp);
    chk({nm, "_t_pronto"}, tp, exp_t);
    chk({nm, "_n_pronto"}, np, 1);
    chk({nm, "_ocupado"}, nb, exp_t + 1);
  endtask

  initial begin
    logic [15:0] r; int nb, np, tp;
    logic [2:0] rop; logic [3:0] rn; int inj;

    #12;
    chk("rst_saida", saida, 16'h0);
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_pronto", pronto, 1'b0);
    reset = 1'b1;
    chk_en = 1'b1;

    caso("load_8001", 3'b001, 4'd0, 16'h8001, 16'h8001, 1, -1);
    caso("sra3", 3'b100, 4'd3, 16'h0, 16'hF000, 3, -1);
    chk("model_sra3", m_word, 16'hF000);
    caso("load_00ff", 3'b001, 4'd0, 16'h00FF, 16'h00FF, 1, -1);
    caso("sll4", 3'b010, 4'd4, 16'h0, 16'h0FF0, 4, -1);
    caso("load_f00f", 3'b001, 4'd0, 16'hF00F, 16'hF00F, 1, -1);
    caso("srl4", 3'b011, 4'd4, 16'h0, 16'h0F00, 4, -1);
    chk("model_srl4", m_word, 16'h0F00);
    caso("load_8001b", 3'b001, 4'd0, 16'h8001, 16'h8001, 1, -1);
    caso("rol1", 3'b110, 4'd1, 16'h0, ROT ? 16'h0003 : 16'h8001, 1, -1);
    caso("load_8001c", 3'b001, 4'd0, 16'h8001, 16'h8001, 1, -1);
    caso("ror1", 3'b101, 4'd1, 16'h0, ROT ? 16'hC000 : 16'h8001, 1, -1);
    chk("model_ror1", m_word, ROT ? 16'hC000 : 16'h8001);
    caso("load_1234", 3'b001, 4'd0, 16'h1234, 16'h1234, 1, -1);
    caso("sll0", 3'b010, 4'd0, 16'h0, 16'h1234, 1, -1);
    caso("nop", 3'b000, 4'd9, 16'hBEEF, 16'h1234, 1, -1);
    caso("reserved", 3'b111, 4'd9, 16'hBEEF, 16'h1234, 1, -1);
    caso("load_ffff", 3'b001, 4'd0, 16'hFFFF, 16'hFFFF, 1, -1);
    caso("srl15", 3'b011, 4'd15, 16'h0, 16'h0001, 15, -1);
    caso("load_f0f0", 3'b001, 4'd0, 16'hF0F0, 16'hF0F0, 1, -1);
    caso("sra5_ign", 3'b100, 4'd5, 16'h0, 16'hFF87, 5, 2);

    caso("load_00ff_b", 3'b001, 4'd0, 16'h00FF, 16'h00FF, 1, -1);
    @(negedge clock);
    inicio = 1'b1; controle = 3'b010; n = 4'd10;
    @(negedge clock);
    inicio = 1'b0;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_saida", saida, 16'h0);
    chk("async_rst_ocupado", ocupado, 1'b0);
    chk("async_rst_pronto", pronto, 1'b0);
    #1 reset = 1'b1;
    caso("load_a5a5", 3'b001, 4'd0, 16'hA5A5, 16'hA5A5, 1, -1);

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clock);
        controle = 3'($urandom); n = 4'($urandom); entrada = 16'($urandom);
      end
      rop = 3'($urandom);
      rn  = 4'($urandom);
      inj = (rop >= 3'b010 && rop <= 3'b100 && rn > 4'd4) ? int'($urandom_range(0, 3)) : -1;
      do_op(rop, rn, 16'($urandom), inj, r, nb, np, tp);
      chk("rnd_n_pronto", np, 1);
    end

    repeat (2) @(negedge clock);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
